line_sequencer: RTL
===================

// Module: line_sequencer
// PURPOSE
//  Frame/line controller placed directly upstream of the 12-bit pixel counter.
//  Holds the counter's enable (b12_enb) high for each active line and consumes its endLine flag.
//  Inserts a fixed horizontal blank after each line, which also clears the counter.
//  Counts lines per frame and issues an endFrame pulse to the downstream pattern logic.
// PARAMETERS
//  LINES_NORMAL  1024  lines per frame when test=0
//  LINES_TEST    4     lines per frame when test=1
//  BLANK_CYCLES  8     horizontal blank length in clk cycles; legal range 2..255
//  LINE_W        11    width of line_cnt; must hold max(LINES_NORMAL,LINES_TEST)-1
// PORTS
//  clk       in   1       master clock, rising edge
//  rst       in   1       asynchronous active-high reset
//  start     in   1       1-cycle request to begin a frame; honoured only in IDLE
//  abort     in   1       synchronous stop; returns the block to IDLE
//  test      in   1       mode select, sampled at start; 1=test, 0=normal
//  endLine   in   1       terminal-count flag from the pixel counter (combinational there)
//  b12_enb   out  1       registered enable to the pixel counter
//  h_blank   out  1       registered; 1 during horizontal blank
//  line_cnt  out  LINE_W  index of the current line, 0-based
//  endFrame  out  1       registered 1-cycle pulse after the last line's blank
//  busy      out  1       1 in every state except IDLE
// BEHAVIOUR
//  Reset (async, rst=1):
//   - state=IDLE; b12_enb=0, h_blank=0, endFrame=0, busy=0, line_cnt=0.
//   - blank counter=0; mode_q=0.
//  States: IDLE, ACTIVE, BLANK, FEND.
//  IDLE:
//   - start=1 & abort=0 -> ACTIVE; latch mode_q<=test; line_cnt<=0; b12_enb<=1.
//   - b12_enb is high from the first cycle after start.
//  ACTIVE:
//   - b12_enb=1.
//   - endLine=1 sampled -> BLANK; b12_enb<=0, h_blank<=1, blank counter<=0.
//   - The counter therefore sees enable low on the next edge and clears to 0.
//  BLANK:
//   - Lasts exactly BLANK_CYCLES cycles, b12_enb=0 throughout.
//   - endLine is ignored here.
//   - On the last cycle: if line_cnt==LINES-1 -> FEND.
//   - Otherwise -> ACTIVE; line_cnt+1; b12_enb<=1, h_blank<=0.
//   - LINES = mode_q ? LINES_TEST : LINES_NORMAL.
//  FEND:
//   - endFrame=1 for exactly 1 cycle; line_cnt<=0, h_blank<=0.
//   - Then -> IDLE.
//  Start handling:
//   - A start during FEND is honoured, so back-to-back frames are possible.
//   - start in ACTIVE or BLANK is ignored.
//  Mode:
//   - A test change mid-frame has no effect; mode_q holds until the next start.
//  abort=1 in any state:
//   - Next state is IDLE; all outputs take their reset values on the next edge.
//   - abort wins over start and endLine in the same cycle.
//  Line count:
//   - line_cnt increments only on the BLANK->ACTIVE transition.
//   - It never wraps inside a frame.
//  Line timing (normal mode): enable high cycles per line = counter terminal+1 = 4096.
//   Line period = 4096 + BLANK_CYCLES cycles.
// TESTING
//  1. Reset, then start with test=1 and BLANK=8, counter model attached:
//     - 4 ACTIVE runs, 4 blanks of 8 cycles each.
//     - line_cnt steps 0..3; endFrame pulses once.
//     - Afterwards busy=0 and b12_enb=0.
//  2. endLine forced high 1 cycle after ACTIVE entry:
//     - b12_enb drops on the next edge; h_blank=1 for exactly 8 cycles.
//  3. Mid-frame checks:
//     - start pulses are ignored; line_cnt is unchanged.
//     - Toggling test mid-frame does not change the frame length.
//  4. abort on the same cycle as endLine in line 2:
//     - IDLE on the next cycle; line_cnt=0; no endFrame.
//  5. start asserted during FEND:
//     - The new frame begins; b12_enb=1 on the cycle after FEND.
//     - line_cnt=0.
//  6. rst asserted mid-BLANK, asynchronously off-edge:
//     - All outputs are 0 immediately.
//     - After release, the block stays in IDLE until the next start.

Source files
------------

// File: rtl/line_sequencer.sv
// Frame/line controller for the 12-bit pixel counter: it gates the counter
// enable per line, inserts a fixed horizontal blank and signals end of frame.
module line_sequencer #(
  parameter int LINES_NORMAL = 1024,
  parameter int LINES_TEST   = 4,
  parameter int BLANK_CYCLES = 8,
  parameter int LINE_W       = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              test,
  input  logic              endLine,
  output logic              b12_enb,
  output logic              h_blank,
  output logic [LINE_W-1:0] line_cnt,
  output logic              endFrame,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK, FEND} state_e;

  localparam logic [LINE_W-1:0] LAST_NORMAL = LINE_W'(LINES_NORMAL - 1);
  localparam logic [LINE_W-1:0] LAST_TEST   = LINE_W'(LINES_TEST - 1);
  localparam logic [7:0]        BLANK_LAST  = 8'(BLANK_CYCLES - 1);

  state_e            state_q, state_d;
  logic [7:0]        blank_cnt_q, blank_cnt_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic              mode_q, mode_d;
  logic              b12_enb_q, b12_enb_d;
  logic              h_blank_q, h_blank_d;
  logic              end_frame_q, end_frame_d;
  logic              last_line;

  assign last_line = (line_cnt_q == (mode_q ? LAST_TEST : LAST_NORMAL));

  always_comb begin
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    line_cnt_d  = line_cnt_q;
    mode_d      = mode_q;
    b12_enb_d   = b12_enb_q;
    h_blank_d   = h_blank_q;
    end_frame_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ACTIVE;
          mode_d     = test;
          line_cnt_d = '0;
          b12_enb_d  = 1'b1;
        end
      end
      ACTIVE: begin
        if (endLine) begin
          state_d     = BLANK;
          b12_enb_d   = 1'b0;
          h_blank_d   = 1'b1;
          blank_cnt_d = '0;
        end
      end
      BLANK: begin
        if (blank_cnt_q == BLANK_LAST) begin
          h_blank_d = 1'b0;
          if (last_line) begin
            state_d     = FEND;
            end_frame_d = 1'b1;
          end else begin
            state_d    = ACTIVE;
            line_cnt_d = line_cnt_q + 1'b1;
            b12_enb_d  = 1'b1;
          end
        end else begin
          blank_cnt_d = blank_cnt_q + 8'd1;
        end
      end
      FEND: begin
        // A start here chains straight into the next frame.
        state_d    = IDLE;
        line_cnt_d = '0;
        h_blank_d  = 1'b0;
        if (start) begin
          state_d   = ACTIVE;
          mode_d    = test;
          b12_enb_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d     = IDLE;
      blank_cnt_d = '0;
      line_cnt_d  = '0;
      b12_enb_d   = 1'b0;
      h_blank_d   = 1'b0;
      end_frame_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      blank_cnt_q <= '0;
      line_cnt_q  <= '0;
      mode_q      <= 1'b0;
      b12_enb_q   <= 1'b0;
      h_blank_q   <= 1'b0;
      end_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
      line_cnt_q  <= line_cnt_d;
      mode_q      <= mode_d;
      b12_enb_q   <= b12_enb_d;
      h_blank_q   <= h_blank_d;
      end_frame_q <= end_frame_d;
    end
  end

  assign b12_enb  = b12_enb_q;
  assign h_blank  = h_blank_q;
  assign line_cnt = line_cnt_q;
  assign endFrame = end_frame_q;
  assign busy     = (state_q != IDLE);

endmodule
